// File: rtl/excep_pkg.sv
// Shared types and helpers for the exception unit.
// Optional handler/epc/eret support is enabled with EXCEP_EPC_EN.
package excep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2
    } state_e;

    localparam int CAUSE_NONE = 0;
    localparam int CAUSE_ADD  = 1;
    localparam int CAUSE_ADDI = 2;
    localparam int CAUSE_SUB  = 3;

    // Cause codes run 1..n, so 0 stays free for "no exception".
    function automatic int cause_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/excep_prio_enc.sv
// Lowest-index-first priority encoder for exception selection.
// Used by excep_unit; independent of EXCEP_EPC_EN.
module excep_prio_enc
    import excep_pkg::*;
#(
    parameter int NUM_SRC = 4,
    localparam int IW = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] vec,
    output logic               valid,
    output logic [IW-1:0]      idx,
    output logic [NUM_SRC-1:0] onehot
);

    always_comb begin
        valid  = |vec;
        idx    = '0;
        onehot = '0;
        // Scan downwards so the lowest set bit wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx       = IW'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/excep_unit.sv
// Exception unit: latches requests, takes one by priority, writes r30.
// Define EXCEP_EPC_EN for the handler state, epc capture and eret.
module excep_unit
    import excep_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] mask,
    input  logic [DATA_W-1:0]  pc,
    input  logic               bex_en,
    input  logic               eret,
    output logic               flush,
    output logic               rstatus_we,
    output logic [DATA_W-1:0]  rstatus_data,
    output logic               excep_T,
    output logic [DATA_W-1:0]  status,
    output logic [DATA_W-1:0]  epc,
    output logic               busy
);

    localparam int CW = cause_w(NUM_SRC);
    localparam int IW = idx_w(NUM_SRC);

    state_e             state;
    state_e             state_nx;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] live;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] sel_oh;
    logic               sel_valid;
    logic [IW-1:0]      sel_idx;
    logic [CW-1:0]      cause;
    logic               take;
    logic               leave;

    assign live = pending & mask;

    excep_prio_enc #(
        .NUM_SRC(NUM_SRC)
    ) u_enc (
        .vec   (live),
        .valid (sel_valid),
        .idx   (sel_idx),
        .onehot(sel_oh)
    );

    assign cause = sel_valid ? CW'(sel_idx) + CW'(1) : '0;
    assign take  = (state == TAKE);

    always_comb begin
        state_nx     = state;
        flush        = 1'b0;
        rstatus_we   = 1'b0;
        rstatus_data = '0;
        busy         = 1'b0;
        clr          = '0;
        leave        = 1'b0;
        unique case (state)
            IDLE: begin
                if (|live) state_nx = TAKE;
            end
            TAKE: begin
                flush        = 1'b1;
                rstatus_we   = 1'b1;
                rstatus_data = DATA_W'(cause);
                clr          = sel_oh;
`ifdef EXCEP_EPC_EN
                state_nx     = HANDLER;
`else
                state_nx     = IDLE;
`endif
            end
            HANDLER: begin
`ifdef EXCEP_EPC_EN
                busy = 1'b1;
                if (eret) begin
                    state_nx = IDLE;
                    leave    = 1'b1;
                end
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_nx;
            // A request on the clearing edge keeps its bit set.
            pending <= (pending & ~clr) | req;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            status <= '0;
        end else if (take) begin
            status <= DATA_W'(cause);
        end else if (leave) begin
            status <= '0;
        end
    end

`ifdef EXCEP_EPC_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            epc <= '0;
        end else if (take) begin
            epc <= pc;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{pc, eret};
    assign epc       = '0;
`endif

    assign excep_T = bex_en & (|status);

endmodule

// File: doc/excep_unit.md
# excep_unit

Parametrised exception unit for the five-stage processor. It latches up to NUM_SRC maskable exception requests, such as add/addi/sub overflow and external lines. It then selects one by fixed priority, flushes the pipeline, writes a cause code into rstatus (r30) and captures the faulting PC. It also resolves `bex` against the stored status. It sits beside the execute stage and drives the register-file r30 write port and the fetch-redirect logic.

## Interface
- NUM_SRC, 4: number of request sources; source i reports cause code i+1 (parent wires 0=add ovf, 1=addi ovf, 2=sub ovf).
- DATA_W, 32: width of PC, status and rstatus data.
- clock  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- req  in  NUM_SRC  exception request pulses or levels, sampled every rising edge.
- mask  in  NUM_SRC  1 = source enabled; applied at selection, not at capture.
- pc  in  DATA_W  PC of the instruction currently in execute.
- bex_en  in  1  decoded `bex` in execute.
- eret  in  1  return-from-handler strobe.
- flush  out  1  one-cycle pipeline flush / redirect pulse.
- rstatus_we  out  1  write enable for r30, coincident with flush.
- rstatus_data  out  DATA_W  cause code, zero-extended.
- excep_T  out  1  `bex` taken: bex_en & (status != 0), combinational.
- status  out  DATA_W  last cause code taken; 0 = none.
- epc  out  DATA_W  captured PC of the excepting instruction.
- busy  out  1  handler in progress (HANDLER state).

## Operation
- pending[NUM_SRC-1:0] register: every edge, pending <= (pending & ~clr) | req. Set dominates clear on the same bit.
- Selection: sel = lowest index with (pending & mask) set; cause = sel+1, width ceil(log2(NUM_SRC+1)), zero-extended to DATA_W.
- States are IDLE, TAKE and HANDLER.
  - IDLE: if (pending & mask) != 0 → TAKE. Otherwise stay in IDLE.
  - TAKE (one cycle): flush=1, rstatus_we=1, rstatus_data=cause. On the exit edge: status<=cause, epc<=pc, clr=onehot(sel). Then → HANDLER.
  - HANDLER: busy=1. Requests keep accumulating in pending but are not taken. eret → IDLE and clears status to 0.
- eret outside HANDLER is ignored. Masked pending bits persist until they are unmasked and taken.
- Reset at any time: state=IDLE, pending=0, status=0, epc=0. All outputs are 0 immediately (async).

## Timing
- req high at edge N → pending set at N → TAKE during cycle N+1 (flush, rstatus_we high) → status/epc valid after edge N+2, busy high from N+2.
- excep_T has zero latency from bex_en and reflects status as registered; no bypass of the TAKE-cycle write.
- eret sampled at edge M in HANDLER → IDLE after M. If pending remains, TAKE follows in cycle M+1.
- Minimum exception spacing is 2 cycles without HANDLER (see Configuration). With HANDLER, it is handler length + 1.

## Configuration
- EXCEP_EPC_EN defined: full behaviour above, including the HANDLER state, epc capture and eret.
- EXCEP_EPC_EN undefined: TAKE → IDLE directly, and busy is tied 0. The epc register is removed and epc is tied 0. eret is ignored, and status is cleared only by reset or overwritten by the next cause (legacy sticky-rstatus behaviour).

## Structure
- Shared package excep_pkg contains:
  - the state enum (IDLE, TAKE, HANDLER);
  - cause constants CAUSE_NONE=0, CAUSE_ADD=1, CAUSE_ADDI=2, CAUSE_SUB=3;
  - a cause-width function.
- Sub-module excep_prio_enc (NUM_SRC parameter): lowest-index-first priority encoder producing valid, index and one-hot.

## Test plan
- Reset: resetn low mid-HANDLER → state IDLE, status=0, epc=0, flush=0, busy=0 immediately.
- Single request: req[1] pulse at edge N with mask=4'b1111, pc=0x40 → flush and rstatus_we high in cycle N+1 with rstatus_data=2. After N+2, status=2 and epc=0x40.
- Priority/simultaneous: req=4'b1100 in one cycle → cause 3 taken first. After eret, cause 4 is taken next cycle. Also, req[2] re-asserted in its own TAKE cycle → pending bit stays set.
- Masking: req[0] with mask[0]=0 → no flush for 10 cycles. Unmask → TAKE next cycle with cause 1.
- bex: status=3 and bex_en=1 → excep_T=1. After eret (status=0) → excep_T=0. eret in IDLE has no effect.
- Build with EXCEP_EPC_EN undefined: back-to-back req[0], req[1] → flushes 2 cycles apart, epc stays 0, busy never high.
